vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator: derives a pixel clock-enable from the system clock,

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_sync_delay.sv | 36 +++
 rtl/vga_timing_gen.sv | 185 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, sync polarity
// encodings and a counter-width helper. Imported by the timing generator, its
// delay line and every game top that needs to size coordinate buses.
package vga_pkg;

    // Sync polarity encodings: the value driven while the pulse is active.
    typedef enum logic {
        ACTIVE_LOW  = 1'b0,
        ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // Default 640x480@60 raster from a 50 MHz system clock.
    localparam int   DEF_CLK_DIV  = 2;
    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam logic DEF_H_POL    = ACTIVE_LOW;
    localparam logic DEF_V_POL    = ACTIVE_LOW;
    localparam int   DEF_PIX_LAT  = 1;

    // Width of the {hsync, vsync, de} bundle carried by the delay line.
    localparam int SYNC_W = 3;

    // Bits needed to hold values 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-enable qualified shift register for the {hsync, vsync, de} bundle.
// Each stage advances only when ce is high, so the delay is DEPTH pixels
// regardless of the system-to-pixel clock ratio. Stages reset to RST_VAL,
// which the parent sets to inactive sync levels and de = 0.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int               DEPTH   = 1,
    parameter logic [SYNC_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [SYNC_W-1:0] din,
    output logic [SYNC_W-1:0] dout
);

    logic [SYNC_W-1:0] stage [DEPTH];

    // Shift the bundle one stage per pixel enable; async reset to idle levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else if (ce) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Divides the system clock into a pixel enable,
// runs horizontal/vertical counters and decodes hsync, vsync, display enable,
// pixel coordinates and line/frame start pulses. All outputs are registered
// and change only on the clock edge that raises o_pix_ce, so they are stable
// for the whole clock in which o_pix_ce is high.
//
// Optional feature macro VGA_PIX_DELAY_EN: when defined, o_hsync/o_vsync/o_de
// are delayed by PIX_LAT pixel enables (vga_sync_delay) to line up with a
// PIX_LAT-deep renderer pipeline; o_x, o_y and the pulses are never delayed.
// When undefined, PIX_LAT has no effect and sync/de align with o_x/o_y.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = DEF_H_POL,
    parameter logic V_POL    = DEF_V_POL,
    parameter int   PIX_LAT  = DEF_PIX_LAT,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  XW       = cnt_width(H_TOTAL),
    localparam int  YW       = cnt_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_pix_ce,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start
);

    // Parameter sanity: a zero divider or an out-of-range pipeline depth
    // would silently produce a broken raster.
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_pix_lat
        $error("vga_timing_gen: PIX_LAT must be in 1..4");
    end

    localparam int DW = cnt_width(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

    // Sync/active boundaries are one bit wider than the counters because a
    // window may end exactly at H_TOTAL / V_TOTAL (zero back porch).
    localparam logic [XW:0] H_ACT_END = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] HS_START  = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0] HS_END    = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0] V_ACT_END = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0] VS_START  = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0] VS_END    = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Pixel clock-enable divider
    // ------------------------------------------------------------------
    logic [DW-1:0] div;
    logic          tick;

    // tick marks the system clock edge on which the raster advances; the
    // registered o_pix_ce goes high on that same edge.
    assign tick = (div == DIV_LAST);

    // Divider counts 0..CLK_DIV-1 and registers the pixel enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            o_pix_ce <= 1'b0;
        end else begin
            o_pix_ce <= tick;
            div      <= tick ? '0 : div + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Raster counters and decode of the next position
    // ------------------------------------------------------------------
    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic [XW-1:0] h_next;
    logic [YW-1:0] v_next;
    logic          h_wrap;
    logic          hs_on;
    logic          vs_on;
    logic          de_on;

    // Next raster position and the sync/de windows it falls into.
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_next = h_wrap ? '0 : h_cnt + 1'b1;
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
        hs_on = ({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END);
        vs_on = ({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END);
        de_on = ({1'b0, h_next} < H_ACT_END) && ({1'b0, v_next} < V_ACT_END);
    end

    // Internal counters start at the last raster position so the first
    // pixel enable after reset lands on (0,0) with both start pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
        end else if (tick) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // ------------------------------------------------------------------
    // Registered, pixel-aligned outputs
    // ------------------------------------------------------------------
    logic hs_q;
    logic vs_q;
    logic de_q;

    // Coordinates and pixel-aligned sync/de update on the advancing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_x  <= '0;
            o_y  <= '0;
            hs_q <= ~H_POL;
            vs_q <= ~V_POL;
            de_q <= 1'b0;
        end else if (tick) begin
            o_x  <= h_next;
            o_y  <= v_next;
            hs_q <= hs_on ? H_POL : ~H_POL;
            vs_q <= vs_on ? V_POL : ~V_POL;
            de_q <= de_on;
        end
    end

    // Start pulses are high only in the clock that carries o_pix_ce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_line_start  <= tick && h_wrap;
            o_frame_start <= tick && h_wrap && (v_next == '0);
        end
    end

`ifdef VGA_PIX_DELAY_EN
    // Delay sync/de by PIX_LAT pixel enables to match the renderer pipeline.
    logic [SYNC_W-1:0] sync_dly;

    vga_sync_delay #(
        .DEPTH   (PIX_LAT),
        .RST_VAL ({~H_POL, ~V_POL, 1'b0})
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .ce   (tick),
        .din  ({hs_q, vs_q, de_q}),
        .dout (sync_dly)
    );

    assign o_hsync = sync_dly[2];
    assign o_vsync = sync_dly[1];
    assign o_de    = sync_dly[0];
`else
    // No renderer pipeline to match: sync/de stay aligned with o_x/o_y.
    assign o_hsync = hs_q;
    assign o_vsync = vs_q;
    assign o_de    = de_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen. DUT A uses the default 640x480
// timing; DUT B uses a tiny 14x7 raster (CLK_DIV=1, hsync active-high,
// PIX_LAT=2) so whole frames fit in a short run.
module tb_vga_timing_gen;

`ifdef VGA_PIX_DELAY_EN
    localparam int LAG_A = 1;
    localparam int LAG_B = 2;
`else
    localparam int LAG_A = 0;
    localparam int LAG_B = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #10 clk = ~clk;   // 50 MHz

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // ---------------- DUTs ----------------
    logic       pix_ce_a, hsync_a, vsync_a, de_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       pix_ce_b, hsync_b, vsync_b, de_b, ls_b, fs_b;
    logic [3:0] x_b;
    logic [2:0] y_b;

    vga_timing_gen u_dut_a (
        .clk(clk), .rst(rst_a), .o_pix_ce(pix_ce_a), .o_hsync(hsync_a),
        .o_vsync(vsync_a), .o_de(de_a), .o_x(x_a), .o_y(y_a),
        .o_line_start(ls_a), .o_frame_start(fs_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0), .PIX_LAT(2)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .o_pix_ce(pix_ce_b), .o_hsync(hsync_b),
        .o_vsync(vsync_b), .o_de(de_b), .o_x(x_b), .o_y(y_b),
        .o_line_start(ls_b), .o_frame_start(fs_b)
    );

    // ---------------- reference raster model ----------------
    // mx/my: expected position; history keeps the last 5 positions so the
    // delayed sync/de expectations can look back LAG pixels.
    int mx, my;
    int hx[5];
    int hy[5];
    bit hv[5];

    task automatic model_reset(input int htot, input int vtot);
        mx = htot - 1;
        my = vtot - 1;
        for (int i = 0; i < 5; i++) begin
            hx[i] = 0; hy[i] = 0; hv[i] = 1'b0;
        end
    endtask

    task automatic model_adv(input int htot, input int vtot);
        if (mx == htot - 1) begin
            mx = 0;
            my = (my == vtot - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
        for (int i = 4; i > 0; i--) begin
            hx[i] = hx[i-1]; hy[i] = hy[i-1]; hv[i] = hv[i-1];
        end
        hx[0] = mx; hy[0] = my; hv[0] = 1'b1;
    endtask

    // Default timing: hsync low x=656..751, vsync low y=490..491, active 640x480.
    function automatic logic exp_hs_a();
        if (!hv[LAG_A]) return 1'b1;
        return (hx[LAG_A] >= 656 && hx[LAG_A] < 752) ? 1'b0 : 1'b1;
    endfunction
    function automatic logic exp_vs_a();
        if (!hv[LAG_A]) return 1'b1;
        return (hy[LAG_A] >= 490 && hy[LAG_A] < 492) ? 1'b0 : 1'b1;
    endfunction
    function automatic logic exp_de_a();
        if (!hv[LAG_A]) return 1'b0;
        return (hx[LAG_A] < 640 && hy[LAG_A] < 480) ? 1'b1 : 1'b0;
    endfunction

    // Small timing: hsync high x=10..11, vsync low y=5, active 8x4.
    function automatic logic exp_hs_b();
        if (!hv[LAG_B]) return 1'b0;
        return (hx[LAG_B] >= 10 && hx[LAG_B] < 12) ? 1'b1 : 1'b0;
    endfunction
    function automatic logic exp_vs_b();
        if (!hv[LAG_B]) return 1'b1;
        return (hy[LAG_B] == 5) ? 1'b0 : 1'b1;
    endfunction
    function automatic logic exp_de_b();
        if (!hv[LAG_B]) return 1'b0;
        return (hx[LAG_B] < 8 && hy[LAG_B] < 4) ? 1'b1 : 1'b0;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_a = 1'b1;
        repeat (5) @(negedge clk);   // 100 ns of reset
        checks++; if (pix_ce_a !== 1'b0) begin failures++; $display("FAIL rst_pix_ce: got %b want 0", pix_ce_a); end
        checks++; if (hsync_a !== 1'b1) begin failures++; $display("FAIL rst_hsync: got %b want 1", hsync_a); end
        checks++; if (vsync_a !== 1'b1) begin failures++; $display("FAIL rst_vsync: got %b want 1", vsync_a); end
        checks++; if (de_a !== 1'b0) begin failures++; $display("FAIL rst_de: got %b want 0", de_a); end
        checks++; if (x_a !== 10'd0) begin failures++; $display("FAIL rst_x: got %0d want 0", x_a); end
        checks++; if (y_a !== 10'd0) begin failures++; $display("FAIL rst_y: got %0d want 0", y_a); end
        checks++; if (ls_a !== 1'b0 || fs_a !== 1'b0) begin failures++; $display("FAIL rst_pulses: got ls=%b fs=%b want 0 0", ls_a, fs_a); end
        rst_a = 1'b0;
        model_reset(800, 525);
        @(negedge clk);
        checks++; if (pix_ce_a !== 1'b0) begin failures++; $display("FAIL first_ce_early: got %b want 0", pix_ce_a); end
        @(negedge clk);
        checks++; if (pix_ce_a !== 1'b1) begin failures++; $display("FAIL first_ce: got %b want 1", pix_ce_a); end
        model_adv(800, 525);
        checks++; if (x_a !== 10'(mx) || y_a !== 10'(my)) begin failures++; $display("FAIL first_xy: got %0d,%0d want %0d,%0d", x_a, y_a, mx, my); end
        checks++; if (de_a !== exp_de_a()) begin failures++; $display("FAIL first_de: got %b want %b", de_a, exp_de_a()); end
        checks++; if (fs_a !== 1'b1) begin failures++; $display("FAIL first_frame_start: got %b want 1", fs_a); end
        checks++; if (ls_a !== 1'b1) begin failures++; $display("FAIL first_line_start: got %b want 1", ls_a); end
    endtask

    // Three full default lines, pixel by pixel; entered right after pixel (0,0).
    task automatic test_line();
        int npix = 0;
        int last_ls = cyc;
        int hs_first = -1;
        for (int c = 0; c < 4800; c++) begin
            @(negedge clk);
            checks++; if (pix_ce_a !== ((c % 2) == 1)) begin failures++; $display("FAIL line_pix_ce: clk %0d got %b want %b", c, pix_ce_a, (c % 2) == 1); end
            if (pix_ce_a === 1'b1) begin
                npix++;
                model_adv(800, 525);
                checks++; if (x_a !== 10'(mx) || y_a !== 10'(my)) begin failures++; $display("FAIL line_xy: got %0d,%0d want %0d,%0d", x_a, y_a, mx, my); end
                checks++; if (hsync_a !== exp_hs_a()) begin failures++; $display("FAIL line_hsync: at x=%0d got %b want %b", mx, hsync_a, exp_hs_a()); end
                checks++; if (vsync_a !== exp_vs_a()) begin failures++; $display("FAIL line_vsync: at y=%0d got %b want %b", my, vsync_a, exp_vs_a()); end
                checks++; if (de_a !== exp_de_a()) begin failures++; $display("FAIL line_de: at x=%0d got %b want %b", mx, de_a, exp_de_a()); end
                checks++; if (ls_a !== (mx == 0)) begin failures++; $display("FAIL line_start: at x=%0d got %b want %b", mx, ls_a, mx == 0); end
                checks++; if (fs_a !== (mx == 0 && my == 0)) begin failures++; $display("FAIL line_frame_start: at x=%0d y=%0d got %b", mx, my, fs_a); end
                if (hs_first < 0 && hsync_a === 1'b0) hs_first = int'(x_a);
                if (ls_a === 1'b1) begin
                    checks++; if (cyc - last_ls !== 1600) begin failures++; $display("FAIL line_period: got %0d clk want 1600", cyc - last_ls); end
                    last_ls = cyc;
                end
            end else begin
                checks++; if (ls_a !== 1'b0 || fs_a !== 1'b0) begin failures++; $display("FAIL pulse_width: got ls=%b fs=%b without pix_ce", ls_a, fs_a); end
            end
        end
        checks++; if (npix !== 2400) begin failures++; $display("FAIL line_pix_count: got %0d want 2400", npix); end
        checks++; if (hs_first !== 656 + LAG_A) begin failures++; $display("FAIL hsync_start_x: got %0d want %0d", hs_first, 656 + LAG_A); end
    endtask

    // Reset asserted mid-line: outputs must drop to reset values at once.
    task automatic test_midframe_reset();
        bit hit = 1'b0;
        for (int c = 0; c < 4000 && !hit; c++) begin
            @(negedge clk);
            if (pix_ce_a === 1'b1) begin
                model_adv(800, 525);
                if (mx == 300 && my == 3) hit = 1'b1;
            end
        end
        checks++; if (!hit) begin failures++; $display("FAIL mid_reach: got timeout want position 300,3"); end
        checks++; if (x_a !== 10'd300 || y_a !== 10'd3) begin failures++; $display("FAIL mid_xy: got %0d,%0d want 300,3", x_a, y_a); end
        #2 rst_a = 1'b1;
        #1;
        checks++; if (x_a !== 10'd0 || y_a !== 10'd0) begin failures++; $display("FAIL mid_rst_xy: got %0d,%0d want 0,0", x_a, y_a); end
        checks++; if (hsync_a !== 1'b1 || vsync_a !== 1'b1) begin failures++; $display("FAIL mid_rst_sync: got hs=%b vs=%b want 1 1", hsync_a, vsync_a); end
        checks++; if (de_a !== 1'b0 || pix_ce_a !== 1'b0) begin failures++; $display("FAIL mid_rst_de_ce: got de=%b ce=%b want 0 0", de_a, pix_ce_a); end
        checks++; if (ls_a !== 1'b0 || fs_a !== 1'b0) begin failures++; $display("FAIL mid_rst_pulses: got ls=%b fs=%b want 0 0", ls_a, fs_a); end
        @(negedge clk);
        rst_a = 1'b0;
        model_reset(800, 525);
        @(negedge clk);
        checks++; if (pix_ce_a !== 1'b0) begin failures++; $display("FAIL mid_ce_early: got %b want 0", pix_ce_a); end
        @(negedge clk);
        model_adv(800, 525);
        checks++; if (pix_ce_a !== 1'b1) begin failures++; $display("FAIL mid_first_ce: got %b want 1", pix_ce_a); end
        checks++; if (x_a !== 10'd0 || y_a !== 10'd0) begin failures++; $display("FAIL mid_restart_xy: got %0d,%0d want 0,0", x_a, y_a); end
        checks++; if (fs_a !== 1'b1 || ls_a !== 1'b1) begin failures++; $display("FAIL mid_restart_pulses: got fs=%b ls=%b want 1 1", fs_a, ls_a); end
        checks++; if (de_a !== exp_de_a()) begin failures++; $display("FAIL mid_restart_de: got %b want %b", de_a, exp_de_a()); end
    endtask

    // Two full frames of the small raster with CLK_DIV = 1.
    task automatic test_small_frame();
        int de_cnt = 0;
        int vs_cnt = 0;
        int hs_cnt = 0;
        int last_fs = -1;
        rst_b = 1'b1;
        @(negedge clk);
        checks++; if (pix_ce_b !== 1'b0) begin failures++; $display("FAIL b_rst_ce: got %b want 0", pix_ce_b); end
        checks++; if (hsync_b !== 1'b0 || vsync_b !== 1'b1) begin failures++; $display("FAIL b_rst_sync: got hs=%b vs=%b want 0 1", hsync_b, vsync_b); end
        checks++; if (de_b !== 1'b0 || x_b !== 4'd0 || y_b !== 3'd0) begin failures++; $display("FAIL b_rst_de_xy: got de=%b x=%0d y=%0d want 0 0 0", de_b, x_b, y_b); end
        rst_b = 1'b0;
        model_reset(14, 7);
        for (int c = 0; c < 196; c++) begin
            @(negedge clk);
            checks++; if (pix_ce_b !== 1'b1) begin failures++; $display("FAIL b_pix_ce: clk %0d got %b want 1", c, pix_ce_b); end
            model_adv(14, 7);
            checks++; if (x_b !== 4'(mx) || y_b !== 3'(my)) begin failures++; $display("FAIL b_xy: got %0d,%0d want %0d,%0d", x_b, y_b, mx, my); end
            checks++; if (hsync_b !== exp_hs_b()) begin failures++; $display("FAIL b_hsync: at x=%0d got %b want %b", mx, hsync_b, exp_hs_b()); end
            checks++; if (vsync_b !== exp_vs_b()) begin failures++; $display("FAIL b_vsync: at y=%0d got %b want %b", my, vsync_b, exp_vs_b()); end
            checks++; if (de_b !== exp_de_b()) begin failures++; $display("FAIL b_de: at x=%0d y=%0d got %b want %b", mx, my, de_b, exp_de_b()); end
            checks++; if (ls_b !== (mx == 0)) begin failures++; $display("FAIL b_line_start: at x=%0d got %b", mx, ls_b); end
            checks++; if (fs_b !== (mx == 0 && my == 0)) begin failures++; $display("FAIL b_frame_start: at x=%0d y=%0d got %b", mx, my, fs_b); end
            if (de_b === 1'b1) de_cnt++;
            if (vsync_b === 1'b0) vs_cnt++;
            if (hsync_b === 1'b1) hs_cnt++;
            if (fs_b === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++; if (cyc - last_fs !== 98) begin failures++; $display("FAIL b_frame_period: got %0d want 98", cyc - last_fs); end
                end
                last_fs = cyc;
            end
        end
        checks++; if (de_cnt !== 64) begin failures++; $display("FAIL b_de_count: got %0d want 64", de_cnt); end
        checks++; if (vs_cnt !== 28) begin failures++; $display("FAIL b_vsync_count: got %0d want 28", vs_cnt); end
        checks++; if (hs_cnt !== 28) begin failures++; $display("FAIL b_hsync_count: got %0d want 28", hs_cnt); end
    endtask

    // Lag between frame start and the first de pixel.
    task automatic test_pix_delay();
        int lag = -1;
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        checks++; if (fs_b !== 1'b1) begin failures++; $display("FAIL dly_frame_start: got %b want 1", fs_b); end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (lag < 0 && de_b === 1'b1) lag = k;
        end
        checks++; if (lag !== LAG_B) begin failures++; $display("FAIL dly_de_lag: got %0d want %0d", lag, LAG_B); end
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_line();
        test_midframe_reset();
        test_small_frame();
        test_pix_delay();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
